imem_loader: RTL and testbench

Boot-time instruction-memory writer for the five-stage processor. It receives a framed little-endian byte stream over a valid/ready handshake, assembles 16-bit instruction words and writes them sequentially into instruction memory. It verifies a trailing checksum and holds the core in reset until a good image is loaded. It is the write side of the instruction-memory port that the fetch stage reads.

---
 rtl/imem_loader.sv | 113 +++++++++++
 tb/tb_imem_loader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: accepts a framed little-endian byte stream,
// writes 16-bit words sequentially from BASE, verifies a checksum and gates cpu_hold.
module imem_loader #(
    parameter int W      = 16,
    parameter int ADDR_W = 20,
    parameter int BASE   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [W-1:0]      imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    typedef enum logic [3:0] {
        BOOT, LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, CK_LO, CK_HI, DONE, ERR
    } state_t;

    // Length limit compared at a width wide enough for both N and 2^ADDR_W
    localparam int LW = (ADDR_W + 1 > 17) ? ADDR_W + 1 : 17;
    localparam logic [LW-1:0] LIMIT = LW'((64'd1 << ADDR_W) - 64'(BASE));

    state_t      state, state_n;
    logic [15:0] len;
    logic [15:0] sum;
    logic [15:0] index;
    logic [7:0]  lo;
    logic        accept;
    logic [15:0] len_full;
    logic [15:0] word;

    assign s_ready  = (state == LEN_LO) || (state == LEN_HI) || (state == DATA_LO) ||
                      (state == DATA_HI) || (state == CK_LO) || (state == CK_HI);
    assign accept   = s_valid && s_ready;
    assign len_full = {s_data, len[7:0]};
    assign word     = {s_data, lo};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= BOOT;
        else      state <= state_n;
    end

    always_comb begin
        state_n  = state;
        imem_we  = 1'b0;
        cpu_hold = 1'b1;
        done     = 1'b0;
        err      = 1'b0;
        case (state)
            BOOT:    state_n = LEN_LO;
            LEN_LO:  if (accept) state_n = LEN_HI;
            LEN_HI: begin
                if (accept) begin
                    if (LW'(len_full) > LIMIT) state_n = ERR;
                    else if (len_full == 16'd0) state_n = CK_LO;
                    else                        state_n = DATA_LO;
                end
            end
            DATA_LO: if (accept) state_n = DATA_HI;
            DATA_HI: if (accept) state_n = WRITE;
            WRITE: begin
                imem_we = 1'b1;
                state_n = (index + 16'd1 == len) ? CK_LO : DATA_LO;
            end
            CK_LO:   if (accept) state_n = CK_HI;
            CK_HI:   if (accept) state_n = (word == sum) ? DONE : ERR;
            DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
            end
            ERR:     err = 1'b1;
            default: state_n = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len        <= '0;
            sum        <= '0;
            index      <= '0;
            lo         <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            case (state)
                BOOT: begin
                    sum   <= '0;
                    index <= '0;
                end
                LEN_LO:  if (accept) len[7:0] <= s_data;
                LEN_HI:  if (accept) len[15:8] <= s_data;
                DATA_LO: if (accept) lo <= s_data;
                DATA_HI: begin
                    if (accept) begin
                        imem_wdata <= W'(word);
                        sum        <= sum + word;
                        imem_addr  <= ADDR_W'(BASE) + ADDR_W'(index);
                    end
                end
                WRITE:   index <= index + 16'd1;
                CK_LO:   if (accept) lo <= s_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame table plus gap, overflow and reset sequences.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_valid2 = 1'b0;

    logic        s_ready, imem_we, cpu_hold, done, err;
    logic [19:0] imem_addr;
    logic [15:0] imem_wdata;

    logic        s_ready2, imem_we2, cpu_hold2, done2, err2;
    logic [3:0]  imem_addr2;
    logic [15:0] imem_wdata2;

    imem_loader #(.W(16), .ADDR_W(20), .BASE(0)) u_dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    imem_loader #(.W(16), .ADDR_W(4), .BASE(0)) u_small (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid2), .s_ready(s_ready2),
        .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
        .cpu_hold(cpu_hold2), .done(done2), .err(err2)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int sel = 0;
    int viol = 0;
    int writes2 = 0;
    logic        we_prev = 1'b0;
    logic [19:0] wa[$];
    logic [15:0] wd[$];

    // Write log plus protocol checks: single-cycle strobes, s_ready low while writing
    always @(negedge clk) begin
        if (imem_we) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
            if (s_ready) viol++;
            if (we_prev) viol++;
        end
        we_prev = imem_we;
        if (imem_we2) writes2++;
    end

    typedef struct {
        logic [7:0]  b[8];
        int          nb;
        int          nw;
        logic [15:0] wdat[2];
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        s_data = b;
        if (sel != 0) s_valid2 = 1'b1;
        else          s_valid  = 1'b1;
        t = 0;
        while (!((sel != 0) ? s_ready2 : s_ready) && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: byte %0h not accepted within 20 cycles", b);
        end
        @(posedge clk);
        #1;
        s_valid  = 1'b0;
        s_valid2 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        s_valid = 1'b0;
        s_valid2 = 1'b0;
        #2;
        chk("reset_state", {s_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err}, 64'h4);
        chk("reset_state_small", {s_ready2, imem_we2, imem_addr2, imem_wdata2, cpu_hold2, done2, err2}, 64'h4);
        wa.delete();
        wd.delete();
        viol = 0;
        writes2 = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_vec(input int k, input bit gaps);
        int blocked;
        sel = 0;
        do_reset();
        for (int i = 0; i < tbl[k].nb; i++)
            send(tbl[k].b[i], gaps ? int'($urandom_range(0, 3)) : 0);
        chk("done", done, tbl[k].exp_done);
        chk("err", err, tbl[k].exp_err);
        chk("cpu_hold", cpu_hold, !tbl[k].exp_done);
        chk("write_count", wa.size(), tbl[k].nw);
        for (int i = 0; i < tbl[k].nw && i < wa.size(); i++) begin
            chk("write_addr", wa[i], i);
            chk("write_data", wd[i], tbl[k].wdat[i]);
        end
        chk("strobe_protocol", viol, 0);
        blocked = 0;
        @(negedge clk);
        s_data = 8'h5A;
        s_valid = 1'b1;
        repeat (5) begin
            if (s_ready) blocked++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk("no_accept_after_end", blocked, 0);
        chk("end_state_held", {done, err}, {tbl[k].exp_done, tbl[k].exp_err});
    endtask

    initial begin
        tbl[0] = '{b: '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hAC, 8'h68}, nb: 8, nw: 2,
                   wdat: '{16'h1234, 16'h5678}, exp_done: 1'b1, exp_err: 1'b0};
        tbl[1] = '{b: '{8'h01, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00}, nb: 6, nw: 1,
                   wdat: '{16'hFFFF, 16'h0000}, exp_done: 1'b0, exp_err: 1'b1};
        tbl[2] = '{b: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, nb: 4, nw: 0,
                   wdat: '{16'h0000, 16'h0000}, exp_done: 1'b1, exp_err: 1'b0};
        tbl[3] = '{b: '{8'h01, 8'h00, 8'hCD, 8'hAB, 8'hCD, 8'hAB, 8'h00, 8'h00}, nb: 6, nw: 1,
                   wdat: '{16'hABCD, 16'h0000}, exp_done: 1'b1, exp_err: 1'b0};
        // 0xFFFF + 0x0002 wraps to 0x0001
        tbl[4] = '{b: '{8'h02, 8'h00, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h01, 8'h00}, nb: 8, nw: 2,
                   wdat: '{16'hFFFF, 16'h0002}, exp_done: 1'b1, exp_err: 1'b0};

        for (int k = 0; k < 5; k++) run_vec(k, 1'b0);
        run_vec(0, 1'b1);
        run_vec(4, 1'b1);

        // Overflow: N=17 into a 16-word space
        sel = 1;
        do_reset();
        send(8'h11, 0);
        send(8'h00, 0);
        chk("ovf_err", err2, 1'b1);
        chk("ovf_hold", cpu_hold2, 1'b1);
        chk("ovf_ready", s_ready2, 1'b0);
        repeat (3) @(negedge clk);
        chk("ovf_writes", writes2, 0);

        // Boundary: N=16 exactly fits
        do_reset();
        send(8'h10, 0);
        send(8'h00, 0);
        chk("fit_err", err2, 1'b0);
        chk("fit_ready", s_ready2, 1'b1);
        sel = 0;

        // Reset during the WRITE cycle of the first word
        do_reset();
        send(8'h02, 0);
        send(8'h00, 0);
        send(8'h34, 0);
        send(8'h12, 0);
        chk("mid_we_before_reset", imem_we, 1'b1);
        rst = 1'b0;
        #1;
        chk("mid_reset_state", {s_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err}, 64'h4);
        wa.delete();
        wd.delete();
        viol = 0;
        @(negedge clk);
        rst = 1'b1;
        send(8'h01, 0);
        send(8'h00, 0);
        send(8'hCD, 0);
        send(8'hAB, 0);
        send(8'hCD, 0);
        send(8'hAB, 0);
        chk("mid_done", done, 1'b1);
        chk("mid_write_count", wa.size(), 1);
        if (wa.size() > 0) begin
            chk("mid_write_addr", wa[0], 0);
            chk("mid_write_data", wd[0], 16'hABCD);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
